// File: rtl/dma_pkg.sv
// Shared definitions for the mem_copy_dma block: FSM state encoding and default length width.
package dma_pkg;

  localparam int DMA_LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    FIN  = 3'd3,
    ABT  = 3'd4
  } dma_state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// Single-channel word copy engine: alternating read/write of one word at a time.
// Optional DMA_CHECKSUM_EN adds a running modulo-2^32 sum of every word written.
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int LEN_W = DMA_LEN_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  dma_state_e       state, state_nxt;
  logic [31:0]      src_ptr, dst_ptr, data_buf;
  logic [LEN_W-1:0] cnt;
  logic             accept;

  // start is only honoured in IDLE, and wins over a simultaneous abort
  assign accept = (state == IDLE) && start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (len == '0) ? FIN : RD;
      RD:   state_nxt = abort ? ABT : WR;
      // the write in this cycle still lands; abort only redirects afterwards
      WR:   state_nxt = abort ? ABT : ((cnt == LEN_W'(1)) ? FIN : RD);
      FIN:  state_nxt = IDLE;
      ABT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: ;
      RD: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = src_ptr;
      end
      WR: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = dst_ptr;
        mem_wdata = data_buf;
      end
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ABT: begin
        busy    = 1'b1;
        aborted = 1'b1;
      end
      default: ;
    endcase
  end

  // Pointers wrap naturally at 2^32; overlapping regions replicate by design.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr  <= '0;
      dst_ptr  <= '0;
      cnt      <= '0;
      data_buf <= '0;
    end else begin
      if (accept && (len != '0)) begin
        src_ptr <= src_addr;
        dst_ptr <= dst_addr;
        cnt     <= len;
      end
      if (state == RD) begin
        data_buf <= mem_rdata;
        src_ptr  <= src_ptr + 32'd1;
      end
      if (state == WR) begin
        dst_ptr <= dst_ptr + 32'd1;
        cnt     <= cnt - LEN_W'(1);
      end
    end
  end

`ifdef DMA_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            checksum <= '0;
    else if (accept)         checksum <= '0;
    else if (state == WR)    checksum <= checksum + data_buf;
  end
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomised self-checking bench for mem_copy_dma against a word-by-word copy model.
module tb_mem_copy_dma;

  localparam int LEN_W = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, aborted, mem_read, mem_write;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
`ifdef DMA_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  mem_copy_dma #(.LEN_W(LEN_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .aborted(aborted),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMA_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  // 256-word memory, addresses alias on the low byte
  logic [31:0] mem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_wa = '0;
  logic [31:0] tb_wd = '0;
  always @(posedge clock) begin
    if (mem_write)  mem[mem_addr[7:0]] <= mem_wdata;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  logic [31:0] ref_mem [256];
  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(negedge clock);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clock);
    tb_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic mem_cmp(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  // One transfer; abort_c = cycle (1 = first after the start edge) in which abort is raised, 0 = never.
  task automatic xfer(input string tag, input logic [31:0] s, input logic [31:0] d, input int n,
                      input int abort_c, input bit abort_w_start, input bit hold_start);
    int w, nrd_exp, term_exp, term, nrd, nwr, nboth, rd_bad, wr_bad, busy_bad;
    bit ab_exp, ab_got;
    logic [31:0] sum, cks;
    ab_exp = (abort_c >= 1) && (abort_c <= 2 * n);
    if (ab_exp) begin
      w = abort_c / 2; nrd_exp = (abort_c + 1) / 2; term_exp = abort_c + 1;
    end else begin
      w = n; nrd_exp = n; term_exp = (n == 0) ? 1 : 2 * n + 1;
    end
    sum = '0;
    for (int i = 0; i < w; i++) begin
      ref_mem[8'(d + 32'(i))] = ref_mem[8'(s + 32'(i))];
      sum += ref_mem[8'(d + 32'(i))];
    end
    @(negedge clock);
    start = 1'b1; src_addr = s; dst_addr = d; len = LEN_W'(n); abort = abort_w_start;
    term = 0; nrd = 0; nwr = 0; nboth = 0; rd_bad = 0; wr_bad = 0; busy_bad = 0;
    ab_got = 1'b0; cks = '0;
    for (int c = 1; c <= 200 && term == 0; c++) begin
      @(negedge clock);
      if (!hold_start) start = 1'b0;
      abort = (c == abort_c);
      if (mem_read && mem_write) nboth++;
      if (mem_read) begin
        if (mem_addr !== s + 32'(nrd)) rd_bad++;
        nrd++;
      end
      if (mem_write) begin
        if (mem_addr !== d + 32'(nwr)) wr_bad++;
        nwr++;
      end
      if (busy !== 1'b1) busy_bad++;
      if (done || aborted) begin
        term = c; ab_got = aborted;
`ifdef DMA_CHECKSUM_EN
        cks = checksum;
`endif
      end
    end
    start = 1'b0;
    chk({tag, " term_cycle"}, 32'(term), 32'(term_exp));
    chk({tag, " aborted"}, 32'(ab_got), 32'(ab_exp));
    chk({tag, " reads"}, 32'(nrd), 32'(nrd_exp));
    chk({tag, " writes"}, 32'(nwr), 32'(w));
    chk({tag, " rd_wr_overlap"}, 32'(nboth), 32'd0);
    chk({tag, " addr_seq"}, 32'(rd_bad + wr_bad), 32'd0);
    chk({tag, " busy"}, 32'(busy_bad), 32'd0);
`ifdef DMA_CHECKSUM_EN
    chk({tag, " checksum"}, cks, sum);
`endif
    @(negedge clock);
    abort = 1'b0;
    chk({tag, " idle_after"}, {27'd0, busy, done, aborted, mem_read, mem_write}, 32'd0);
    chk({tag, " idle_addr"}, mem_addr | mem_wdata, 32'd0);
    mem_cmp({tag, " mem"});
  endtask

  initial begin
    #2;
    chk("reset_flags", {27'd0, busy, done, aborted, mem_read, mem_write}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
    poke(8'd0, 32'd20123);
    poke(8'd1, 32'd18833);
    poke(8'd2, 32'd39041);
    poke(8'd3, 32'hFFFF_BFD8);  // -16424

    xfer("basic3", 32'd0, 32'd100, 3, 0, 1'b0, 1'b0);
    chk("basic3_w0", mem[100], 32'd20123);
    chk("basic3_w2", mem[102], 32'd39041);
    xfer("len0", 32'd5, 32'd6, 0, 0, 1'b0, 1'b0);
    xfer("wrap", 32'hFFFF_FFFF, 32'd200, 2, 0, 1'b0, 1'b0);
    chk("wrap_copy", mem[201], 32'd20123);
    xfer("abort_wr2", 32'd20, 32'd110, 5, 4, 1'b0, 1'b0);
    xfer("abort_rd2", 32'd30, 32'd120, 5, 3, 1'b0, 1'b0);
    xfer("abort_fin", 32'd40, 32'd130, 2, 5, 1'b0, 1'b0);
    xfer("start_abort", 32'd50, 32'd140, 2, 0, 1'b1, 1'b1);
    xfer("overlap", 32'd60, 32'd61, 4, 0, 1'b0, 1'b0);

`ifdef DMA_CHECKSUM_EN
    xfer("cks4", 32'd0, 32'd150, 4, 0, 1'b0, 1'b0);
    chk("cks4_value", checksum, 32'd61573);
`endif

    // reset mid-RD of the third word: only two words may land
    @(negedge clock);
    start = 1'b1; src_addr = 32'd70; dst_addr = 32'd160; len = LEN_W'(5);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("rst_pre_rd", {31'd0, mem_read}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_async_flags", {27'd0, busy, done, aborted, mem_read, mem_write}, 32'd0);
    chk("rst_async_addr", mem_addr, 32'd0);
    ref_mem[160] = ref_mem[70];
    ref_mem[161] = ref_mem[71];
    @(negedge clock);
    chk("rst_no_pulse", {30'd0, done, aborted}, 32'd0);
    reset_n = 1'b1;
    mem_cmp("rst_mem");
    xfer("after_rst", 32'd80, 32'd170, 1, 0, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      int n, ac;
      n  = $urandom_range(0, 8);
      ac = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * n + 1) : 0;
      xfer($sformatf("rand%0d", t), 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
           n, ac, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
